i2s_audio_serializer: RTL
=========================

// Module: i2s_audio_serializer
// PURPOSE
//  Sink for the parallel 16-bit left/right samples produced by the tone generators.
//  Latches one stereo pair per frame and serializes it as standard I2S (MSB first, one-SCK delay)
//  with MCLK/SCK/LRCK generated locally, driving the Pmod I2S2 DAC pins.
//  Fixed clock ratios: 100 MHz clk -> MCLK 25 MHz, SCK 6.25 MHz, LRCK 97.656 kHz (64 SCK/frame).
// PARAMETERS
//  DATA_W  16  sample width in bits, legal 1..31, serialized into 32-slot half-frames
// PORTS
//  clk              in   1       system clock (100 MHz)
//  rst              in   1       synchronous, active-high reset
//  audio_in_left    in   DATA_W  left sample, two's complement, passed through unaltered
//  audio_in_right   in   DATA_W  right sample, two's complement, passed through unaltered
//  mute             in   1       1 = next latched pair forced to zero
//  audio_mclk       out  1       master clock = cnt[1]
//  audio_sck        out  1       serial bit clock = cnt[3]
//  audio_lrck       out  1       word select = cnt[9]; 0 = left, 1 = right
//  audio_sdin       out  1       serial data, registered
//  sample_tick      out  1       1-cycle pulse: new pair latched, visible this frame
// BEHAVIOUR
//  - Single clock domain (clk); reset is synchronous and active-high.
//  - cnt: 10-bit free-running counter, +1 every clk, wraps 1023->0. Frame = 1024 clk.
//  - rst=1 at an edge: cnt<=0, hold_l<=0, hold_r<=0, audio_sdin<=0, sample_tick<=0.
//    mclk/sck/lrck are direct cnt bits, so all outputs are 0 in the cycle after reset.
//  - Reset mid-frame: frame aborted, no partial word. Restart at left slot 0.
//    First frame after reset is silent because hold=0.
//  - Latch: on the edge where cnt==1023, hold_l<=mute?0:audio_in_left, hold_r<=mute?0:audio_in_right.
//    Both channels are latched on the same edge, so no L/R tearing.
//    Input changes at any other time are ignored until the next latch.
//  - sample_tick <= (cnt==1023). High exactly during cnt==0, once per 1024 clk.
//    First high at the 1024th cycle after reset release.
//  - Slot index s = cnt[8:4] (0..31) within half-frame h = cnt[9]. One slot = one SCK period = 16 clk.
//  - sdin timing: updated only on edges where cnt[3:0]==15 (SCK falling), so it is stable across SCK rising (cnt[3:0]=8).
//    New value = bit for slot s'=next cnt[8:4] in half h'=next cnt[9].
//  - Bit mapping: word = h' ? hold_r : hold_l.
//    Slot s' in 1..DATA_W carries word[DATA_W-s']. Slot 0 and slots DATA_W+1..31 carry 0.
//  - Slot 0 of each half is the I2S one-bit delay after the LRCK edge, so MSB is in slot 1.
//  - mute has no effect mid-frame. It takes effect at the next latch. Deassert restores input on the following latch.
//  - No backpressure: the upstream generator must hold samples valid; sample_tick may be used to advance it.
//  - Latency: input sampled at cnt==1023 -> MSB on sdin from cnt==16 (left) / cnt==528 (right).
// TESTING
//  1 Reset: rst=1 for 3 clk mid-frame -> next cycle all outputs 0. After release:
//    mclk toggles every 2 clk, sck every 8, lrck every 512, sample_tick at clk 1024, 2048.
//  2 Data: left=16'hA5C3, right=16'h0F0F held -> sampling sdin at sck rising edges in frame 2:
//    left slots 1..16 = 1010_0101_1100_0011, right slots 1..16 = 0000_1111_0000_1111.
//    Slot 0 and slots 17..31 = 0.
//  3 Mid-frame change: left 16'h8001 -> 16'h7FFE at cnt=300 -> current frame still shows 8001.
//    Next frame shows 7FFE. Right is unaffected.
//  4 Mute: mute=1 at cnt=500 -> current frame unchanged, following frame sdin all 0.
//    mute=0 -> data returns one frame later.
//  5 Reset mid-word: rst at cnt=700 (right MSB region) -> sdin 0 next cycle, lrck=0.
//    First post-reset frame silent; second frame carries current inputs.
//  6 DATA_W=24 build: left=24'h800001 -> slot1=1, slots 2..23=0, slot24=1, slots 25..31=0.

Source files
------------

// File: rtl/i2s_audio_serializer.sv
// I2S transmitter: latches one stereo pair per 1024-clk frame and shifts it out MSB first
// with the standard one-SCK delay after each LRCK edge. MCLK/SCK/LRCK are free-running counter taps.
module i2s_audio_serializer #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] audio_in_left,
  input  logic [DATA_W-1:0] audio_in_right,
  input  logic              mute,
  output logic              audio_mclk,
  output logic              audio_sck,
  output logic              audio_lrck,
  output logic              audio_sdin,
  output logic              sample_tick
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned SLOT_W = 5;
  localparam int unsigned WORD_W = 32;
  localparam logic [SLOT_W-1:0] LAST_BIT_SLOT = SLOT_W'(DATA_W);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic              sdin_q, sdin_d;
  logic              tick_q, tick_d;

  logic              frame_end;
  logic              sck_fall;
  logic [SLOT_W-1:0] slot_nxt;
  logic [SLOT_W-1:0] bit_idx;
  logic [WORD_W-1:0] word_ext;

  // Next-state: counter, frame latch, and serial bit for the slot that starts on the next edge
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    frame_end = (cnt_q == '1);
    sck_fall  = (cnt_q[3:0] == 4'hF);
    slot_nxt  = cnt_d[8:4];
    word_ext  = cnt_d[9] ? WORD_W'(hold_r_q) : WORD_W'(hold_l_q);
    bit_idx   = LAST_BIT_SLOT - slot_nxt;

    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    sdin_d    = sdin_q;
    tick_d    = frame_end;

    if (frame_end) begin
      hold_l_d = mute ? '0 : audio_in_left;
      hold_r_d = mute ? '0 : audio_in_right;
    end

    // Slot 0 is the one-bit I2S delay; slots past the word are zero padding
    if (sck_fall) begin
      if ((slot_nxt != '0) && (slot_nxt <= LAST_BIT_SLOT)) begin
        sdin_d = word_ext[bit_idx];
      end else begin
        sdin_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      sdin_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      sdin_q   <= sdin_d;
      tick_q   <= tick_d;
    end
  end

  assign audio_mclk  = cnt_q[1];
  assign audio_sck   = cnt_q[3];
  assign audio_lrck  = cnt_q[9];
  assign audio_sdin  = sdin_q;
  assign sample_tick = tick_q;

endmodule
